uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the CPU's 16-bit SRAM-style bus, in parallel with the block RAM. It decodes two word addresses at `BASE_ADDR`. CPU writes to the data register enqueue bytes into a small FIFO, and a serializer drains the FIFO onto `tx` as 8N1 frames. Reads return status with the same one-cycle registered latency as the block RAM, so the top-level read mux can select on `hit`.

---
 rtl/uart_mmio_pkg.sv | 22 ++
 rtl/uart_tx_mmio_if.sv | 19 +
 rtl/uart_tx_mmio_sync_fifo.sv | 56 +++++
 rtl/uart_tx_mmio.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, status bit positions and serializer states.
package uart_mmio_pkg;

    // Word offsets from BASE_ADDR
    localparam logic [15:0] REG_STAT = 16'd0;
    localparam logic [15:0] REG_DATA = 16'd1;

    // Status register bit positions
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_FULL = 1;
    localparam int unsigned STAT_OVF  = 2;

    // Serializer states
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU SRAM-style bus as seen by a memory-mapped peripheral.
interface uart_tx_mmio_if;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        wren_n;
    logic        oen_n;
    logic        hit;

    modport master (
        output address, data_in, wren_n, oen_n,
        input  data_out, hit
    );

    modport slave (
        input  address, data_in, wren_n, oen_n,
        output data_out, hit
    );
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with occupancy count. Head entry is presented
// combinationally on dout. Push and pop may coincide when full; when
// empty a coinciding pop is ignored and only the push takes effect.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: status register at BASE_ADDR,
// data register at BASE_ADDR+1, FIFO-buffered serializer on tx.
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_mmio_if.slave bus,
    output logic          tx
);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + REG_STAT;
    localparam logic [15:0] DATA_ADDR = BASE_ADDR + REG_DATA;

    tx_state_t        state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             ovf;

    logic             sel_stat;
    logic             sel_data;
    logic             wr;
    logic             rd;
    logic             push;
    logic             pop;
    logic             bit_last;
    logic             busy;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic [15:0]      stat_word;

    assign sel_stat = (bus.address == STAT_ADDR);
    assign sel_data = (bus.address == DATA_ADDR);
    assign wr       = !bus.wren_n;
    assign rd       = !bus.oen_n && bus.wren_n;
    assign push     = wr && sel_data;
    assign bit_last = (bit_cnt == CNT_LAST);
    assign pop      = !fifo_empty &&
                      ((state == S_IDLE) || (state == S_STOP && bit_last));
    assign busy     = (state != S_IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (bus.data_in[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Status word assembly
    always_comb begin
        stat_word            = '0;
        stat_word[STAT_BUSY] = busy;
        stat_word[STAT_FULL] = fifo_full;
        stat_word[STAT_OVF]  = ovf;
    end

    // Sticky overflow flag; a new overflow beats a clearing status read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf <= 1'b1;
        end else if (rd && sel_stat) begin
            ovf <= 1'b0;
        end
    end

    // Registered read data and hit, one cycle after the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out <= '0;
            bus.hit      <= 1'b0;
        end else if (rd && sel_stat) begin
            bus.data_out <= stat_word;
            bus.hit      <= 1'b1;
        end else if (rd && sel_data) begin
            bus.data_out <= 16'(fifo_count);
            bus.hit      <= 1'b1;
        end else begin
            bus.hit      <= 1'b0;
        end
    end

    // Serializer FSM; tx is registered and driven one bit ahead of the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg   <= fifo_dout;
                        tx      <= 1'b0;
                        bit_cnt <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shreg <= fifo_dout;
                            tx    <= 1'b0;
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a scoreboard of expected bytes
// is filled as writes are driven, and a line monitor decodes each frame
// on tx sample by sample against the head of the scoreboard.
module tb_uart_tx_mmio;
    localparam int CPB = 4;
    localparam logic [15:0] A_STAT = 16'hFF00;
    localparam logic [15:0] A_DATA = 16'hFF01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int frames_done = 0;
    int start_last = 0;
    int start_prev = 0;
    logic [7:0] sb [$];

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .BASE_ADDR    (16'hFF00),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One bus cycle; called at a negedge, returns at the next negedge
    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic wr, input logic rd);
        bus.address = a;
        bus.data_in = d;
        bus.wren_n  = !wr;
        bus.oen_n   = !rd;
        @(negedge clk);
        bus.wren_n  = 1'b1;
        bus.oen_n   = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frames_done", frames_done, target);
    endtask

    // Line monitor: every sample of every frame compared to the expected byte
    initial begin
        logic [7:0] exp;
        logic       have;
        logic       aborted;
        logic       expb;
        int         bitn;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                start_prev = start_last;
                start_last = cyc;
                aborted    = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 0, 1);
                    have = 1'b0;
                    exp  = '0;
                end else begin
                    exp  = sb.pop_front();
                    have = 1'b1;
                end
                for (int s = 0; s < 10*CPB; s++) begin
                    if (s > 0) @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    if (have && !aborted) begin
                        bitn = s / CPB;
                        if (bitn == 0)      expb = 1'b0;
                        else if (bitn == 9) expb = 1'b1;
                        else                expb = exp[bitn-1];
                        chk($sformatf("tx_bit%0d_byte%02h", bitn, exp), tx, expb);
                    end
                end
                if (!aborted) frames_done++;
            end
        end
    end

    initial begin
        bus.address = '0;
        bus.data_in = '0;
        bus.wren_n  = 1'b1;
        bus.oen_n   = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Reset state
        chk("rst_tx", tx, 1'b1);
        chk("rst_hit", bus.hit, 1'b0);
        chk("rst_dout", bus.data_out, 16'h0000);
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("rst_stat", bus.data_out, 16'h0000);
        chk("rst_stat_hit", bus.hit, 1'b1);

        // Single byte: write lands at E0, start bit from E1
        sb.push_back(8'h55);
        drive(A_DATA, 16'h1255, 1'b1, 1'b0);
        chk("pre_start_tx", tx, 1'b1);
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("start_lat_tx", tx, 1'b0);
        chk("busy_after_wr", bus.data_out, 16'h0001);
        idle(10);
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("busy_mid_frame", bus.data_out, 16'h0001);
        wait_frames(1, 100);
        idle(2);
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("idle_stat", bus.data_out, 16'h0000);

        // Back-to-back frames abut
        sb.push_back(8'hA5);
        sb.push_back(8'h3C);
        drive(A_DATA, 16'h00A5, 1'b1, 1'b0);
        drive(A_DATA, 16'h003C, 1'b1, 1'b0);
        wait_frames(3, 200);
        chk("b2b_gap", start_last - start_prev, 10*CPB);
        idle(2);

        // Overflow: first byte pops early, four fill the FIFO, sixth is dropped
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb.push_back(8'(8'h11 + i));
            drive(A_DATA, 16'(16'h0011 + i), 1'b1, 1'b0);
        end
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("ovf_stat", bus.data_out, 16'h0007);
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("ovf_cleared", bus.data_out, 16'h0003);
        wait_frames(8, 400);
        idle(2);

        // Write precedence and address decode
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("pre_prec_hit", bus.hit, 1'b1);
        sb.push_back(8'hC3);
        drive(A_DATA, 16'h00C3, 1'b1, 1'b1);
        chk("prec_hit", bus.hit, 1'b0);
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("prec_busy", bus.data_out, 16'h0001);
        drive(16'hFF02, 16'h0077, 1'b1, 1'b0);
        drive(16'hFEFF, 16'h0066, 1'b1, 1'b0);
        drive(16'hFF02, '0, 1'b0, 1'b1);
        chk("dec_ff02_hit", bus.hit, 1'b0);
        chk("dec_ff02_hold", bus.data_out, 16'h0001);
        drive(16'hFEFF, '0, 1'b0, 1'b1);
        chk("dec_feff_hit", bus.hit, 1'b0);
        drive(A_DATA, '0, 1'b0, 1'b1);
        chk("dec_count", bus.data_out, 16'h0000);
        chk("dec_count_hit", bus.hit, 1'b1);
        wait_frames(9, 100);
        idle(2);

        // Count read while the serializer is mid-frame
        sb.push_back(8'hD1);
        drive(A_DATA, 16'h00D1, 1'b1, 1'b0);
        idle(5);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(8'(8'hE0 + i));
            drive(A_DATA, 16'(16'h00E0 + i), 1'b1, 1'b0);
        end
        drive(A_DATA, '0, 1'b0, 1'b1);
        chk("count3", bus.data_out, 16'h0003);
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("count3_stat", bus.data_out, 16'h0001);
        wait_frames(13, 250);
        idle(2);

        // Asynchronous reset mid-frame
        sb.push_back(8'h81);
        drive(A_DATA, 16'h0081, 1'b1, 1'b0);
        idle(16);
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("pre_rst_hit", bus.hit, 1'b1);
        chk("pre_rst_tx", tx, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", tx, 1'b1);
        chk("async_rst_hit", bus.hit, 1'b0);
        chk("async_rst_dout", bus.data_out, 16'h0000);
        sb.delete();
        idle(60);
        rst_n = 1'b1;
        idle(1);
        drive(A_STAT, '0, 1'b0, 1'b1);
        chk("post_rst_stat", bus.data_out, 16'h0000);
        drive(A_DATA, '0, 1'b0, 1'b1);
        chk("post_rst_count", bus.data_out, 16'h0000);
        idle(50);
        chk("post_rst_tx", tx, 1'b1);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
